// File: rtl/predecode_fetch_queue.sv
// Fetch-to-decode instruction queue. Each word is pre-decoded on entry into its
// immediate, opcode class and illegal flag, which are stored alongside the word.
module predecode_fetch_queue #(
  parameter int DEPTH    = 4,
  parameter int PC_WIDTH = 32,
  parameter int M_EXT    = 1,
  parameter int F_EXT    = 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [31:0]                  in_instr_i,
  input  logic [PC_WIDTH-1:0]          in_pc_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [31:0]                  out_instr_o,
  output logic [PC_WIDTH-1:0]          out_pc_o,
  output logic [31:0]                  out_imm_o,
  output logic [1:0]                   out_class_o,
  output logic                         out_illegal_o,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_FLOAD  = 7'b0000111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_ALU_I  = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_FSTORE = 7'b0100111;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_FMADD  = 7'b1000011;
  localparam logic [6:0] OP_FMSUB  = 7'b1000111;
  localparam logic [6:0] OP_FNMSUB = 7'b1001011;
  localparam logic [6:0] OP_FNMADD = 7'b1001111;
  localparam logic [6:0] OP_F_OPS  = 7'b1010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_ECSR   = 7'b1110011;

  localparam logic [1:0] CLS_INT  = 2'd0;
  localparam logic [1:0] CLS_MUL  = 2'd1;
  localparam logic [1:0] CLS_FLT  = 2'd2;
  localparam logic [1:0] CLS_CTRL = 2'd3;

  typedef struct packed {
    logic [31:0]         instr;
    logic [PC_WIDTH-1:0] pc;
    logic [31:0]         imm;
    logic [1:0]          cls;
    logic                illegal;
  } entry_t;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        rm_bad;
  logic        fp_funct7_ok;
  logic [31:0] pd_imm;
  logic [1:0]  pd_class;
  logic        pd_illegal;

  assign opcode = in_instr_i[6:0];
  assign funct3 = in_instr_i[14:12];
  assign funct7 = in_instr_i[31:25];
  assign imm_i  = {{20{in_instr_i[31]}}, in_instr_i[31:20]};
  assign imm_s  = {{20{in_instr_i[31]}}, in_instr_i[31:25], in_instr_i[11:7]};
  assign imm_b  = {{19{in_instr_i[31]}}, in_instr_i[31], in_instr_i[7],
                   in_instr_i[30:25], in_instr_i[11:8], 1'b0};
  assign imm_u  = {in_instr_i[31:12], 12'b0};
  assign imm_j  = {{11{in_instr_i[31]}}, in_instr_i[31], in_instr_i[19:12],
                   in_instr_i[20], in_instr_i[30:21], 1'b0};
  // rm 101/110 are reserved rounding modes
  assign rm_bad = (funct3 == 3'b101) || (funct3 == 3'b110);

  always_comb begin
    fp_funct7_ok = 1'b0;
    case (funct7)
      7'h00, 7'h04, 7'h08, 7'h0C, 7'h2C, 7'h10,
      7'h14, 7'h60, 7'h70, 7'h50, 7'h68, 7'h78: fp_funct7_ok = 1'b1;
      default:                                  fp_funct7_ok = 1'b0;
    endcase
  end

  always_comb begin
    pd_imm     = 32'd0;
    pd_class   = CLS_INT;
    pd_illegal = 1'b0;
    case (opcode)
      OP_LOAD: begin
        pd_imm     = imm_i;
        pd_illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
      end
      OP_FLOAD: begin
        pd_imm   = imm_i;
        pd_class = CLS_FLT;
      end
      OP_FENCE: pd_imm = 32'd0;
      OP_ALU_I: begin
        pd_imm = imm_i;
        if (funct3 == 3'b001)
          pd_illegal = (funct7 != 7'b0000000);
        else if (funct3 == 3'b101)
          pd_illegal = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
      end
      OP_AUIPC, OP_LUI: pd_imm = imm_u;
      OP_STORE: begin
        pd_imm     = imm_s;
        pd_illegal = (funct3 >= 3'b011);
      end
      OP_FSTORE: begin
        pd_imm   = imm_s;
        pd_class = CLS_FLT;
      end
      OP_REG: begin
        if (funct7 == 7'b0000001)
          pd_class = CLS_MUL;
        else if (funct7 == 7'b0100000)
          pd_illegal = (funct3 != 3'b000) && (funct3 != 3'b101);
        else if (funct7 != 7'b0000000)
          pd_illegal = 1'b1;
      end
      OP_FMADD, OP_FMSUB, OP_FNMSUB, OP_FNMADD: begin
        pd_class   = CLS_FLT;
        pd_illegal = rm_bad || (in_instr_i[26:25] != 2'b00);
      end
      OP_F_OPS: begin
        pd_class   = CLS_FLT;
        pd_illegal = rm_bad || !fp_funct7_ok;
      end
      OP_BRANCH: begin
        pd_imm     = imm_b;
        pd_class   = CLS_CTRL;
        pd_illegal = (funct3[2:1] == 2'b01);
      end
      OP_JALR: begin
        pd_imm   = imm_i;
        pd_class = CLS_CTRL;
      end
      OP_JAL: begin
        pd_imm   = imm_j;
        pd_class = CLS_CTRL;
      end
      OP_ECSR: pd_imm = imm_i;
      default: pd_illegal = 1'b1;
    endcase
    if ((pd_class == CLS_MUL) && (M_EXT == 0)) pd_illegal = 1'b1;
    if ((pd_class == CLS_FLT) && (F_EXT == 0)) pd_illegal = 1'b1;
  end

  entry_t             mem_reg [DEPTH];
  entry_t             new_entry;
  entry_t             head;
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [OCC_W-1:0]   occ_reg;
  logic               push;
  logic               pop;

  assign new_entry = '{instr: in_instr_i, pc: in_pc_i, imm: pd_imm,
                       cls: pd_class, illegal: pd_illegal};

  // No pass-through: a full queue refuses a word even if decode pops this cycle.
  assign in_ready_o  = (occ_reg < FULL_OCC) && !flush_i && !rst_i;
  assign out_valid_o = (occ_reg != '0);
  assign push        = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      occ_reg    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
    end else if (flush_i) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      occ_reg    <= '0;
    end else begin
      if (push) begin
        mem_reg[wr_ptr_reg] <= new_entry;
        wr_ptr_reg          <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      if (push && !pop)      occ_reg <= occ_reg + OCC_W'(1);
      else if (pop && !push) occ_reg <= occ_reg - OCC_W'(1);
    end
  end

  assign head          = mem_reg[rd_ptr_reg];
  assign out_instr_o   = head.instr;
  assign out_pc_o      = head.pc;
  assign out_imm_o     = head.imm;
  assign out_class_o   = head.cls;
  assign out_illegal_o = head.illegal;
  assign occupancy_o   = occ_reg;

endmodule

// File: tb/tb_predecode_fetch_queue.sv
// Bench for predecode_fetch_queue: directed test-plan steps followed by random
// traffic, compared each cycle against a queue-based reference model.
module tb_predecode_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_pc;
  logic        in_ready, out_valid, out_illegal;
  logic [31:0] out_instr, out_pc, out_imm;
  logic [1:0]  out_class;
  logic [2:0]  occupancy;
  logic        nx_ready, nx_valid, nx_illegal;
  logic [31:0] nx_instr, nx_pc, nx_imm;
  logic [1:0]  nx_class;
  logic [2:0]  nx_occupancy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  predecode_fetch_queue #(.DEPTH(DEPTH), .PC_WIDTH(32), .M_EXT(1), .F_EXT(1)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_instr_i(in_instr), .in_pc_i(in_pc),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_instr_o(out_instr),
    .out_pc_o(out_pc), .out_imm_o(out_imm), .out_class_o(out_class),
    .out_illegal_o(out_illegal), .occupancy_o(occupancy)
  );

  // Same traffic into a build without the M and F extensions.
  predecode_fetch_queue #(.DEPTH(DEPTH), .PC_WIDTH(32), .M_EXT(0), .F_EXT(0)) dut_nx (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(nx_ready), .in_instr_i(in_instr), .in_pc_i(in_pc),
    .out_valid_o(nx_valid), .out_ready_i(out_ready), .out_instr_o(nx_instr),
    .out_pc_o(nx_pc), .out_imm_o(nx_imm), .out_class_o(nx_class),
    .out_illegal_o(nx_illegal), .occupancy_o(nx_occupancy)
  );

  typedef struct packed { logic [31:0] instr; logic [31:0] pc; } item_t;
  typedef struct packed { logic [31:0] imm; logic [1:0] cls; logic ill; } pd_t;

  item_t q[$];
  bit    storage_zero = 1'b1;

  localparam logic [6:0] OPS [18] = '{7'h03, 7'h07, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h27, 7'h33, 7'h37,
                                      7'h43, 7'h47, 7'h4B, 7'h4F, 7'h53, 7'h63, 7'h67, 7'h6F, 7'h73};
  localparam logic [6:0] FP7 [12] = '{7'h00, 7'h04, 7'h08, 7'h0C, 7'h2C, 7'h10,
                                      7'h14, 7'h60, 7'h70, 7'h50, 7'h68, 7'h78};

  function automatic pd_t ref_decode(input logic [31:0] w, input bit m_ok, input bit f_ok);
    pd_t        r;
    logic [6:0] opc = w[6:0];
    logic [2:0] f3  = w[14:12];
    logic [6:0] f7  = w[31:25];
    int         i_imm = $signed(w[31:20]);
    int         s_imm = $signed({w[31:25], w[11:7]});
    int         b_imm = $signed({w[31], w[7], w[30:25], w[11:8], 1'b0});
    int         j_imm = $signed({w[31], w[19:12], w[20], w[30:21], 1'b0});
    int         u_imm = {w[31:12], 12'h000};
    r = '0;
    case (opc)
      7'h03: begin r.imm = i_imm; r.ill = f3 inside {3'd3, 3'd6, 3'd7}; end
      7'h07: begin r.imm = i_imm; r.cls = 2; end
      7'h0F: ;
      7'h13: begin
        r.imm = i_imm;
        if (f3 == 3'd1) r.ill = (f7 != 7'h00);
        if (f3 == 3'd5) r.ill = !(f7 inside {7'h00, 7'h20});
      end
      7'h17, 7'h37: r.imm = u_imm;
      7'h23: begin r.imm = s_imm; r.ill = (f3 > 3'd2); end
      7'h27: begin r.imm = s_imm; r.cls = 2; end
      7'h33: begin
        if (f7 == 7'h01) r.cls = 1;
        r.ill = !(f7 inside {7'h00, 7'h20, 7'h01}) || (f7 == 7'h20 && !(f3 inside {3'd0, 3'd5}));
      end
      7'h43, 7'h47, 7'h4B, 7'h4F: begin
        r.cls = 2; r.ill = (f3 inside {3'd5, 3'd6}) || (w[26:25] != 2'b00);
      end
      7'h53: begin
        r.cls = 2;
        r.ill = (f3 inside {3'd5, 3'd6});
        if (!(f7 inside {FP7[0], FP7[1], FP7[2], FP7[3], FP7[4], FP7[5],
                         FP7[6], FP7[7], FP7[8], FP7[9], FP7[10], FP7[11]})) r.ill = 1'b1;
      end
      7'h63: begin r.imm = b_imm; r.cls = 3; r.ill = f3 inside {3'd2, 3'd3}; end
      7'h67: begin r.imm = i_imm; r.cls = 3; end
      7'h6F: begin r.imm = j_imm; r.cls = 3; end
      7'h73: r.imm = i_imm;
      default: r.ill = 1'b1;
    endcase
    if (r.cls == 2'd1 && !m_ok) r.ill = 1'b1;
    if (r.cls == 2'd2 && !f_ok) r.ill = 1'b1;
    return r;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r = $urandom;
    logic [6:0]  f7;
    if ($urandom_range(0, 9) == 0) return r;
    case ($urandom_range(0, 4))
      0: f7 = 7'h00;
      1: f7 = 7'h20;
      2: f7 = 7'h01;
      3: f7 = FP7[$urandom_range(0, 11)];
      default: f7 = r[31:25];
    endcase
    return {f7, r[24:15], 3'($urandom_range(0, 7)), r[11:7], OPS[$urandom_range(0, 17)]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic compare();
    pd_t p, pn;
    chk("in_ready", 64'(in_ready), 64'((q.size() < DEPTH) && !flush && !rst));
    chk("occupancy", 64'(occupancy), 64'(q.size()));
    chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
    chk("nx_occupancy", 64'(nx_occupancy), 64'(q.size()));
    if (q.size() != 0) begin
      p  = ref_decode(q[0].instr, 1'b1, 1'b1);
      pn = ref_decode(q[0].instr, 1'b0, 1'b0);
      chk("out_instr", 64'(out_instr), 64'(q[0].instr));
      chk("out_pc", 64'(out_pc), 64'(q[0].pc));
      chk("out_imm", 64'(out_imm), 64'(p.imm));
      chk("out_class", 64'(out_class), 64'(p.cls));
      chk("out_illegal", 64'(out_illegal), 64'(p.ill));
      chk("nx_class", 64'(nx_class), 64'(pn.cls));
      chk("nx_illegal", 64'(nx_illegal), 64'(pn.ill));
    end else if (storage_zero) begin
      chk("zero_head", {out_instr, out_imm}, 64'd0);
      chk("zero_pc_cls", {out_pc, 29'd0, out_class, out_illegal}, 64'd0);
    end
  endtask

  task automatic tick();
    bit pop_ok, push_ok;
    @(posedge clk);
    if (rst) begin
      q.delete();
      storage_zero = 1'b1;
    end else if (flush) begin
      q.delete();
    end else begin
      pop_ok  = (q.size() != 0) && out_ready;
      push_ok = in_valid && (q.size() < DEPTH);
      if (pop_ok) void'(q.pop_front());
      if (push_ok) begin
        q.push_back('{instr: in_instr, pc: in_pc});
        storage_zero = 1'b0;
      end
    end
    #1;
    compare();
  endtask

  task automatic push_hold(input logic [31:0] w, input logic [31:0] pc);
    in_valid = 1'b1; in_instr = w; in_pc = pc; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid = 1'b0; out_ready = 1'b1;
    for (int n = 0; n < 2 * DEPTH && q.size() != 0; n++) tick();
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    push_hold(32'h00500093, 32'h100);
    chk("tp_addi_valid", 64'(out_valid), 64'd1);
    chk("tp_addi_imm", 64'(out_imm), 64'h5);
    chk("tp_addi_class", 64'(out_class), 64'd0);
    chk("tp_addi_illegal", 64'(out_illegal), 64'd0);
    chk("tp_addi_pc", 64'(out_pc), 64'h100);
    drain();

    push_hold(32'hFE000EE3, 32'h104);
    chk("tp_beq_imm", 64'(out_imm), 64'hFFFFFFFC);
    chk("tp_beq_class", 64'(out_class), 64'd3);
    chk("tp_beq_illegal", 64'(out_illegal), 64'd0);
    drain();

    push_hold(32'h022081B3, 32'h108);
    chk("tp_mul_class", 64'(out_class), 64'd1);
    chk("tp_mul_illegal_m1", 64'(out_illegal), 64'd0);
    chk("tp_mul_illegal_m0", 64'(nx_illegal), 64'd1);
    drain();

    push_hold(32'h003100D3, 32'h10C);
    chk("tp_fadd_class", 64'(out_class), 64'd2);
    chk("tp_fadd_illegal", 64'(out_illegal), 64'd0);
    drain();
    push_hold(32'h003150D3, 32'h110);
    chk("tp_fadd_rm101_illegal", 64'(out_illegal), 64'd1);
    drain();

    // Fill, then stream with decode ready: one refused push, then steady state.
    out_ready = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      in_valid = 1'b1; in_instr = 32'h00000013 | (32'(k + 1) << 20); in_pc = 32'h200 + 32'(4 * k);
      tick();
    end
    in_valid = 1'b0;
    chk("full_occupancy", 64'(occupancy), 64'd4);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1; in_instr = 32'h00000093 | (32'(k + 9) << 20); in_pc = 32'h300 + 32'(4 * k);
      tick();
    end
    chk("stream_occupancy", 64'(occupancy), 64'd3);

    flush = 1'b1; in_valid = 1'b1; in_instr = 32'h7FF00113; in_pc = 32'hDEAD0000;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_occupancy", 64'(occupancy), 64'd0);
    chk("flush_valid", 64'(out_valid), 64'd0);
    tick();
    chk("flush_word_dropped", 64'(out_valid), 64'd0);

    // Mid-stream reset drops everything.
    push_hold(32'h00A00193, 32'h400);
    push_hold(32'h00B00213, 32'h404);
    rst = 1'b1;
    tick();
    chk("midreset_valid", 64'(out_valid), 64'd0);
    rst = 1'b0;
    tick();

    for (int n = 0; n < 600; n++) begin
      rst       = ($urandom_range(0, 99) == 0);
      flush     = ($urandom_range(0, 31) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_instr  = rand_instr();
      in_pc     = $urandom;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
